// File: rtl/copy_job_sequencer_if.sv
// Burst handshake between the copy job sequencer (master) and the AXI burst engine (slave).
interface copy_job_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  init;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [8:0]            beats;
    logic                  done;
    logic                  error;

    modport master (
        output init, src_addr, dst_addr, beats,
        input  done, error
    );

    modport slave (
        input  init, src_addr, dst_addr, beats,
        output done, error
    );
endinterface

// File: rtl/copy_job_sequencer.sv
// Splits a register-programmed copy job into AXI bursts that never cross a 4 KB page,
// issuing them one at a time to the burst engine and reporting job status.
module copy_job_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    copy_job_sequencer_if.master  eng,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_error,
    output logic                  sts_aborted,
    output logic [15:0]           sts_bursts
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] src_r;
    logic [ADDR_WIDTH-1:0] dst_r;
    logic [LEN_WIDTH-1:0]  rem_r;
    logic [ADDR_WIDTH-1:0] eng_src_r;
    logic [ADDR_WIDTH-1:0] eng_dst_r;
    logic [8:0]            beats_r;
    logic                  init_r;
    logic                  abort_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic                  aborted_r;
    logic [15:0]           bursts_r;

    logic                  reject_s;
    logic [12:0]           src_room_s;
    logic [12:0]           dst_room_s;
    logic [8:0]            lim_rem_s;
    logic [8:0]            lim_src_s;
    logic [8:0]            beats_s;
    logic [ADDR_WIDTH-1:0] step_s;
    logic [LEN_WIDTH-1:0]  rem_next_s;
    logic                  abort_now_s;

    // Start validation: zero length or any field not beat-aligned is rejected.
    always_comb begin
        reject_s = (cfg_len == {LEN_WIDTH{1'b0}})
                 || ((cfg_len & LEN_WIDTH'(BYTES - 1)) != {LEN_WIDTH{1'b0}})
                 || ((cfg_src_addr & ADDR_WIDTH'(BYTES - 1)) != {ADDR_WIDTH{1'b0}})
                 || ((cfg_dst_addr & ADDR_WIDTH'(BYTES - 1)) != {ADDR_WIDTH{1'b0}});
    end

    // Burst sizing: smallest of remaining beats, max burst and beats left in either 4 KB page.
    always_comb begin
        src_room_s = (13'd4096 - {1'b0, src_r[11:0]}) >> BSHIFT;
        dst_room_s = (13'd4096 - {1'b0, dst_r[11:0]}) >> BSHIFT;
        lim_rem_s  = (rem_r < LEN_WIDTH'(BURST_LEN)) ? rem_r[8:0] : 9'(BURST_LEN);
        lim_src_s  = (src_room_s < {4'b0000, lim_rem_s}) ? src_room_s[8:0] : lim_rem_s;
        beats_s    = (dst_room_s < {4'b0000, lim_src_s}) ? dst_room_s[8:0] : lim_src_s;
    end

    // Post-burst bookkeeping values.
    always_comb begin
        step_s      = ADDR_WIDTH'(beats_r) << BSHIFT;
        rem_next_s  = rem_r - LEN_WIDTH'(beats_r);
        abort_now_s = abort_r | cfg_abort;
    end

    // Job sequencing FSM with all outputs registered.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r   <= ST_IDLE;
            src_r     <= {ADDR_WIDTH{1'b0}};
            dst_r     <= {ADDR_WIDTH{1'b0}};
            rem_r     <= {LEN_WIDTH{1'b0}};
            eng_src_r <= {ADDR_WIDTH{1'b0}};
            eng_dst_r <= {ADDR_WIDTH{1'b0}};
            beats_r   <= 9'd0;
            init_r    <= 1'b0;
            abort_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            aborted_r <= 1'b0;
            bursts_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    init_r <= 1'b0;
                    if (cfg_start) begin
                        if (reject_s) begin
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else begin
                            src_r     <= cfg_src_addr;
                            dst_r     <= cfg_dst_addr;
                            rem_r     <= cfg_len >> BSHIFT;
                            abort_r   <= 1'b0;
                            busy_r    <= 1'b1;
                            done_r    <= 1'b0;
                            error_r   <= 1'b0;
                            aborted_r <= 1'b0;
                            bursts_r  <= 16'd0;
                            state_r   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cfg_abort) begin
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        eng_src_r <= src_r;
                        eng_dst_r <= dst_r;
                        beats_r   <= beats_s;
                        init_r    <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The pulse has already gone out, so an abort here waits for the burst.
                    init_r  <= 1'b0;
                    abort_r <= abort_r | cfg_abort;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng.done) begin
                        bursts_r <= bursts_r + 16'd1;
                        if (eng.error) begin
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            error_r   <= 1'b1;
                            aborted_r <= abort_now_s;
                            state_r   <= ST_IDLE;
                        end else begin
                            src_r <= src_r + step_s;
                            dst_r <= dst_r + step_s;
                            rem_r <= rem_next_s;
                            if (abort_now_s) begin
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                aborted_r <= 1'b1;
                                state_r   <= ST_IDLE;
                            end else if (rem_next_s == {LEN_WIDTH{1'b0}}) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_CALC;
                            end
                        end
                    end else begin
                        abort_r <= abort_now_s;
                    end
                end
                default: begin
                    init_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng.init     = init_r;
    assign eng.src_addr = eng_src_r;
    assign eng.dst_addr = eng_dst_r;
    assign eng.beats    = beats_r;
    assign sts_busy     = busy_r;
    assign sts_done     = done_r;
    assign sts_error    = error_r;
    assign sts_aborted  = aborted_r;
    assign sts_bursts   = bursts_r;
endmodule
